// File: rtl/bin2bcd_multi.sv
// Multi-channel binary-to-BCD converter using repeated decade subtraction, one step per clock.
// All channel results are staged and published to bcd_out/ovf together on the edge into DONE.
module bin2bcd_multi #(
  parameter int CHANNELS = 2,
  parameter int IN_W     = 8,
  parameter int DIGITS   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         free_run,
  input  logic [CHANNELS*IN_W-1:0]     bin_in,
  output logic [CHANNELS*DIGITS*4-1:0] bcd_out,
  output logic [CHANNELS-1:0]          ovf,
  output logic                         busy,
  output logic                         done
);
  localparam int CMP_W = IN_W + 4 * DIGITS;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int K_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CB_W  = DIGITS * 4;

  function automatic logic [CMP_W-1:0] pow10(input int k);
    logic [CMP_W-1:0] p;
    p = CMP_W'(1);
    for (int i = 0; i < k; i++) p = p * CMP_W'(10);
    return p;
  endfunction

  typedef enum logic [1:0] {IDLE, LOAD, CONV, DONE} state_t;

  state_t                     state, state_n;
  logic [CH_W-1:0]            ch;
  logic [CHANNELS*IN_W-1:0]   snap;
  logic [IN_W-1:0]            r, r_sub, snap_ch;
  logic [CMP_W-1:0]           r_w;
  logic [CMP_W-1:0]           dec [1:DIGITS];
  logic [CB_W-1:0]            cnt, chan_bcd;
  logic [CHANNELS*CB_W-1:0]   stage_bcd, stage_bcd_n;
  logic [CHANNELS-1:0]        stage_ovf, stage_ovf_n;
  logic                       hit;
  logic [K_W-1:0]             hit_k;
  logic                       load_snap, commit, commit_ovf, last_ch;

  for (genvar g = 1; g <= DIGITS; g++) begin : g_dec
    assign dec[g] = pow10(g);
  end

  assign snap_ch = snap[ch*IN_W +: IN_W];
  assign r_w     = CMP_W'(r);
  assign last_ch = (ch == CH_W'(CHANNELS - 1));
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  // Highest decade still contained in the remainder; later k overrides earlier.
  always_comb begin
    hit   = 1'b0;
    hit_k = '0;
    r_sub = r;
    for (int k = 1; k < DIGITS; k++) begin
      if (r_w >= dec[k]) begin
        hit   = 1'b1;
        hit_k = K_W'(k);
        r_sub = r - dec[k][IN_W-1:0];
      end
    end
  end

  // Nibble 0 of cnt is never incremented, so OR-ing in the remainder yields digit 0.
  always_comb begin
    chan_bcd = cnt | CB_W'(r_w[3:0]);
    if (commit_ovf) chan_bcd = {DIGITS{4'h9}};
    stage_bcd_n = stage_bcd;
    stage_bcd_n[ch*CB_W +: CB_W] = chan_bcd;
    stage_ovf_n = stage_ovf;
    stage_ovf_n[ch] = commit_ovf;
  end

  always_comb begin
    state_n    = state;
    load_snap  = 1'b0;
    commit     = 1'b0;
    commit_ovf = 1'b0;
    case (state)
      IDLE: if (start || free_run) begin
        load_snap = 1'b1;
        state_n   = LOAD;
      end
      LOAD: if (CMP_W'(snap_ch) >= dec[DIGITS]) begin
        commit     = 1'b1;
        commit_ovf = 1'b1;
      end else begin
        state_n = CONV;
      end
      CONV: if (!hit) commit = 1'b1;
      DONE: if (free_run) begin
        load_snap = 1'b1;
        state_n   = LOAD;
      end else begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (commit) state_n = last_ch ? DONE : LOAD;
  end

  // Control and published outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ch      <= '0;
      bcd_out <= '0;
      ovf     <= '0;
    end else begin
      state <= state_n;
      if (load_snap)              ch <= '0;
      else if (commit && !last_ch) ch <= ch + 1'b1;
      if (commit && last_ch) begin
        bcd_out <= stage_bcd_n;
        ovf     <= stage_ovf_n;
      end
    end
  end

  // Datapath: snapshot, remainder, digit counters, staging buffer
  always_ff @(posedge clk) begin
    if (load_snap) snap <= bin_in;
    if (state == LOAD) begin
      r   <= snap_ch;
      cnt <= '0;
    end else if (state == CONV && hit) begin
      r <= r_sub;
      for (int k = 1; k < DIGITS; k++)
        if (hit_k == K_W'(k)) cnt[k*4 +: 4] <= cnt[k*4 +: 4] + 4'd1;
    end
    if (commit) begin
      stage_bcd <= stage_bcd_n;
      stage_ovf <= stage_ovf_n;
    end
  end

endmodule

// File: tb/tb_bin2bcd_multi.sv
// Directed bench for bin2bcd_multi: default config, a 2-digit config and a 3-channel config.
module tb_bin2bcd_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start_a = 1'b0, free_a = 1'b0, busy_a, done_a;
  logic [15:0] bin_a = '0;
  logic [23:0] bcd_a;
  logic [1:0]  ovf_a;

  logic        start_b = 1'b0, free_b = 1'b0, busy_b, done_b;
  logic [15:0] bin_b = '0;
  logic [15:0] bcd_b;
  logic [1:0]  ovf_b;

  logic        start_c = 1'b0, free_c = 1'b0, busy_c, done_c;
  logic [23:0] bin_c = '0;
  logic [35:0] bcd_c;
  logic [2:0]  ovf_c;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bin2bcd_multi #(.CHANNELS(2), .IN_W(8), .DIGITS(3)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .free_run(free_a), .bin_in(bin_a),
    .bcd_out(bcd_a), .ovf(ovf_a), .busy(busy_a), .done(done_a));

  bin2bcd_multi #(.CHANNELS(2), .IN_W(8), .DIGITS(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .free_run(free_b), .bin_in(bin_b),
    .bcd_out(bcd_b), .ovf(ovf_b), .busy(busy_b), .done(done_b));

  bin2bcd_multi #(.CHANNELS(3), .IN_W(8), .DIGITS(3)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .free_run(free_c), .bin_in(bin_c),
    .bcd_out(bcd_c), .ovf(ovf_c), .busy(busy_c), .done(done_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic done_of(input int sel);
    return (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
  endfunction

  task automatic pulse(input int sel);
    if (sel == 0) start_a = 1'b1;
    else if (sel == 1) start_b = 1'b1;
    else start_c = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  // Edges counted from the start-sampling edge until done is seen; -1 on timeout.
  task automatic wait_done(input int sel, output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int i = 1; i <= 300; i++) begin
      if (busy_of(sel) && !done_of(sel)) bcnt++;
      tick();
      if (done_of(sel)) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic seen;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (bcd_a !== 24'h0) begin failures++; $display("FAIL reset_bcd_a: got %h expected 000000", bcd_a); end
    checks++; if (ovf_a !== 2'b00) begin failures++; $display("FAIL reset_ovf_a: got %b expected 00", ovf_a); end
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin failures++; $display("FAIL reset_busy_done_a: got %b%b expected 00", busy_a, done_a); end
    checks++; if (bcd_b !== 16'h0 || bcd_c !== 36'h0) begin failures++; $display("FAIL reset_bcd_bc: got %h %h expected 0 0", bcd_b, bcd_c); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy_a || done_a || busy_b || done_b || busy_c || done_c || bcd_a != 0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL idle_quiet: got activity=%b expected 0", seen); end
  endtask

  task automatic test_basic();
    int lat, bcnt;
    bin_a = {8'd0, 8'd255};
    pulse(0);
    wait_done(0, lat, bcnt);
    checks++; if (lat !== 11) begin failures++; $display("FAIL basic_latency: got %0d expected 11", lat); end
    checks++; if (bcnt !== 11) begin failures++; $display("FAIL basic_busy_cycles: got %0d expected 11", bcnt); end
    checks++; if (bcd_a !== 24'h000255) begin failures++; $display("FAIL basic_bcd: got %h expected 000255", bcd_a); end
    checks++; if (ovf_a !== 2'b00) begin failures++; $display("FAIL basic_ovf: got %b expected 00", ovf_a); end
    tick();
    checks++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin failures++; $display("FAIL basic_done_one_cycle: got done=%b busy=%b expected 0 0", done_a, busy_a); end

    bin_a = {8'd9, 8'd100};
    pulse(0);
    wait_done(0, lat, bcnt);
    checks++; if (lat !== 5) begin failures++; $display("FAIL pattern2_latency: got %0d expected 5", lat); end
    checks++; if (bcd_a !== 24'h009100) begin failures++; $display("FAIL pattern2_bcd: got %h expected 009100", bcd_a); end
    tick();

    bin_a = {8'd99, 8'd250};
    pulse(0);
    wait_done(0, lat, bcnt);
    checks++; if (lat !== 20) begin failures++; $display("FAIL pattern3_latency: got %0d expected 20", lat); end
    checks++; if (bcd_a !== 24'h099250) begin failures++; $display("FAIL pattern3_bcd: got %h expected 099250", bcd_a); end
    tick();
  endtask

  task automatic test_overflow();
    int lat, bcnt;
    bin_b = {8'd99, 8'd123};
    pulse(1);
    wait_done(1, lat, bcnt);
    checks++; if (lat !== 12) begin failures++; $display("FAIL ovf_latency: got %0d expected 12", lat); end
    checks++; if (bcd_b !== 16'h9999) begin failures++; $display("FAIL ovf_bcd: got %h expected 9999", bcd_b); end
    checks++; if (ovf_b !== 2'b01) begin failures++; $display("FAIL ovf_flags: got %b expected 01", ovf_b); end
    tick();

    bin_b = {8'd10, 8'd100};
    pulse(1);
    wait_done(1, lat, bcnt);
    checks++; if (lat !== 4) begin failures++; $display("FAIL ovf_edge_latency: got %0d expected 4", lat); end
    checks++; if (bcd_b !== 16'h1099) begin failures++; $display("FAIL ovf_edge_bcd: got %h expected 1099", bcd_b); end
    checks++; if (ovf_b !== 2'b01) begin failures++; $display("FAIL ovf_edge_flags: got %b expected 01", ovf_b); end
    tick();
  endtask

  task automatic test_snapshot();
    int dcount, first;
    bin_a = {8'd5, 8'd37};
    pulse(0);
    dcount = 0;
    first  = -1;
    for (int i = 1; i <= 20; i++) begin
      start_a = (i <= 3);
      if (i == 1) bin_a[7:0] = 8'd200;
      tick();
      if (done_a) begin
        dcount++;
        if (first < 0) first = i;
      end
    end
    start_a = 1'b0;
    checks++; if (first !== 7) begin failures++; $display("FAIL snap_latency: got %0d expected 7", first); end
    checks++; if (dcount !== 1) begin failures++; $display("FAIL snap_done_count: got %0d expected 1", dcount); end
    checks++; if (bcd_a !== 24'h005037) begin failures++; $display("FAIL snap_bcd: got %h expected 005037", bcd_a); end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt;
    logic seen;
    bin_a = {8'd0, 8'd42};
    pulse(0);
    wait_done(0, lat, bcnt);
    checks++; if (bcd_a !== 24'h000042 || lat !== 8) begin failures++; $display("FAIL pre_reset_run: got %h lat=%0d expected 000042 lat=8", bcd_a, lat); end
    tick();

    bin_a = {8'd250, 8'd5};
    pulse(0);
    tick(); tick(); tick(); tick();
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL mid_run_busy: got %b expected 1", busy_a); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bcd_a !== 24'h0 || ovf_a !== 2'b00) begin failures++; $display("FAIL mid_reset_outputs: got %h %b expected 000000 00", bcd_a, ovf_a); end
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin failures++; $display("FAIL mid_reset_state: got busy=%b done=%b expected 0 0", busy_a, done_a); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done_a || busy_a || bcd_a != 0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_reset_no_resume: got activity=%b expected 0", seen); end

    bin_a = {8'd12, 8'd34};
    pulse(0);
    wait_done(0, lat, bcnt);
    checks++; if (lat !== 8) begin failures++; $display("FAIL post_reset_latency: got %0d expected 8", lat); end
    checks++; if (bcd_a !== 24'h012034) begin failures++; $display("FAIL post_reset_bcd: got %h expected 012034", bcd_a); end
    tick();
  endtask

  task automatic test_free_run();
    int lat, bcnt;
    logic stable;
    logic [35:0] prev;
    bin_c  = {8'd100, 8'd10, 8'd9};
    free_c = 1'b1;
    tick();
    wait_done(2, lat, bcnt);
    checks++; if (lat !== 8) begin failures++; $display("FAIL fr_first_latency: got %0d expected 8", lat); end
    checks++; if (bcd_c !== 36'h100010009) begin failures++; $display("FAIL fr_first_bcd: got %h expected 100010009", bcd_c); end
    checks++; if (ovf_c !== 3'b000) begin failures++; $display("FAIL fr_first_ovf: got %b expected 000", ovf_c); end

    prev = bcd_c;
    stable = 1'b1;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (done_c) begin lat = i; break; end
      if (bcd_c !== prev) stable = 1'b0;
    end
    checks++; if (lat !== 9) begin failures++; $display("FAIL fr_period: got %0d expected 9", lat); end
    checks++; if (stable !== 1'b1) begin failures++; $display("FAIL fr_stable1: got %b expected 1", stable); end

    bin_c = {8'd0, 8'd21, 8'd255};
    stable = 1'b1;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (done_c) begin lat = i; break; end
      if (bcd_c !== 36'h100010009) stable = 1'b0;
    end
    checks++; if (lat !== 16) begin failures++; $display("FAIL fr_period2: got %0d expected 16", lat); end
    checks++; if (stable !== 1'b1) begin failures++; $display("FAIL fr_stable2: got %b expected 1", stable); end
    checks++; if (bcd_c !== 36'h000021255) begin failures++; $display("FAIL fr_new_bcd: got %h expected 000021255", bcd_c); end

    free_c = 1'b0;
    tick();
    checks++; if (busy_c !== 1'b0 || done_c !== 1'b0) begin failures++; $display("FAIL fr_stop: got busy=%b done=%b expected 0 0", busy_c, done_c); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_snapshot();
    test_reset_mid();
    test_free_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
